// File: rtl/ssd1306_command_decoder.sv
// SSD1306 command/data decoder: interprets SPI command bytes and turns data bytes into windowed bitmap RAM writes.
// Optional build macro SSD1306_ADDR_MODE_EN enables vertical/page addressing modes and the page-mode pointer commands.
module ssd1306_command_decoder #(
    parameter int COLUMNS       = 128,
    parameter int PAGES         = 12,
    parameter int ADDRESS_WIDTH = 11
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [7:0]               Byte_i,
    input  logic                     ByteValid_i,
    input  logic                     DC_i,
    input  logic                     CsStart_i,
    output logic                     WriteEnable_o,
    output logic [ADDRESS_WIDTH-1:0] WriteAddress_o,
    output logic [7:0]               WriteData_o,
    output logic                     DisplayOn_o,
    output logic                     Invert_o,
    output logic [7:0]               Contrast_o
);
    localparam int CW = $clog2(COLUMNS);
    localparam int PW = $clog2(PAGES);

    typedef enum logic [2:0] {
        IDLE, ARG_CONTRAST, ARG_COL_START, ARG_COL_END,
        ARG_PAGE_START, ARG_PAGE_END, ARG_MODE, ARG_SKIP
    } state_t;

    function automatic logic [CW-1:0] sat_col(input logic [7:0] v);
        if (v > 8'(COLUMNS - 1)) return CW'(COLUMNS - 1);
        return CW'(v);
    endfunction

    function automatic logic [PW-1:0] sat_page(input logic [7:0] v);
        if (v > 8'(PAGES - 1)) return PW'(PAGES - 1);
        return PW'(v);
    endfunction

    state_t state_q, state_d, state_eff;
    logic [CW-1:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
    logic [PW-1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
    logic                     we_q, we_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]               data_q, data_d;
    logic                     disp_q, disp_d;
    logic                     inv_q, inv_d;
    logic [7:0]               contrast_q, contrast_d;

    logic [CW-1:0] col_adv, col_inc, col_arg, col_end_arg;
    logic [PW-1:0] page_adv, page_inc, page_arg, page_end_arg;
    logic          col_wrap, page_wrap;

    // A CS falling edge aborts any pending command before the same-cycle byte is decoded.
    assign state_eff = CsStart_i ? IDLE : state_q;

    assign col_arg      = sat_col(Byte_i);
    assign col_end_arg  = (col_arg < col_start_q) ? col_start_q : col_arg;
    assign page_arg     = sat_page(Byte_i);
    assign page_end_arg = (page_arg < page_start_q) ? page_start_q : page_arg;

    assign col_wrap  = (col_q == col_end_q);
    assign page_wrap = (page_q == page_end_q);
    assign col_inc   = col_wrap ? col_start_q : col_q + 1'b1;
    assign page_inc  = page_wrap ? page_start_q : page_q + 1'b1;

`ifdef SSD1306_ADDR_MODE_EN
    logic [1:0]    mode_q, mode_d;
    logic [7:0]    col8;
    logic [CW-1:0] col_nib_arg;

    assign col8        = 8'(col_q);
    assign col_nib_arg = sat_col(Byte_i[4] ? {Byte_i[3:0], col8[3:0]} : {col8[7:4], Byte_i[3:0]});

    always_comb begin
        col_adv  = col_inc;
        page_adv = col_wrap ? page_inc : page_q;
        if (mode_q == 2'b01) begin
            page_adv = page_inc;
            col_adv  = page_wrap ? col_inc : col_q;
        end else if (mode_q == 2'b10) begin
            page_adv = page_q;
        end
    end
`else
    always_comb begin
        col_adv  = col_inc;
        page_adv = col_wrap ? page_inc : page_q;
    end
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            col_q        <= '0;
            page_q       <= '0;
            col_start_q  <= '0;
            col_end_q    <= CW'(COLUMNS - 1);
            page_start_q <= '0;
            page_end_q   <= PW'(PAGES - 1);
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            disp_q       <= 1'b0;
            inv_q        <= 1'b0;
            contrast_q   <= 8'h7F;
`ifdef SSD1306_ADDR_MODE_EN
            mode_q       <= 2'b00;
`endif
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            page_q       <= page_d;
            col_start_q  <= col_start_d;
            col_end_q    <= col_end_d;
            page_start_q <= page_start_d;
            page_end_q   <= page_end_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            disp_q       <= disp_d;
            inv_q        <= inv_d;
            contrast_q   <= contrast_d;
`ifdef SSD1306_ADDR_MODE_EN
            mode_q       <= mode_d;
`endif
        end
    end

    always_comb begin
        state_d = state_eff;
        if (ByteValid_i) begin
            if (DC_i) begin
                state_d = IDLE;
            end else begin
                case (state_eff)
                    IDLE: begin
                        case (Byte_i)
                            8'h81:                         state_d = ARG_CONTRAST;
                            8'h21:                         state_d = ARG_COL_START;
                            8'h22:                         state_d = ARG_PAGE_START;
                            8'h20:                         state_d = ARG_MODE;
                            8'hA8, 8'hD3, 8'hD5, 8'hD9,
                            8'hDA, 8'hDB, 8'h8D:           state_d = ARG_SKIP;
                            default:                       state_d = IDLE;
                        endcase
                    end
                    ARG_COL_START:  state_d = ARG_COL_END;
                    ARG_PAGE_START: state_d = ARG_PAGE_END;
                    default:        state_d = IDLE;
                endcase
            end
        end
    end

    always_comb begin
        col_d        = col_q;
        page_d       = page_q;
        col_start_d  = col_start_q;
        col_end_d    = col_end_q;
        page_start_d = page_start_q;
        page_end_d   = page_end_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;
        disp_d       = disp_q;
        inv_d        = inv_q;
        contrast_d   = contrast_q;
`ifdef SSD1306_ADDR_MODE_EN
        mode_d       = mode_q;
`endif
        if (ByteValid_i && DC_i) begin
            we_d   = 1'b1;
            data_d = Byte_i;
            addr_d = ADDRESS_WIDTH'(page_q) * ADDRESS_WIDTH'(COLUMNS) + ADDRESS_WIDTH'(col_q);
            col_d  = col_adv;
            page_d = page_adv;
        end else if (ByteValid_i) begin
            case (state_eff)
                IDLE: begin
                    case (Byte_i)
                        8'hAE: disp_d = 1'b0;
                        8'hAF: disp_d = 1'b1;
                        8'hA6: inv_d  = 1'b0;
                        8'hA7: inv_d  = 1'b1;
                        default: begin
`ifdef SSD1306_ADDR_MODE_EN
                            if (mode_q == 2'b10) begin
                                if (Byte_i[7:4] == 4'hB) page_d = sat_page({4'h0, Byte_i[3:0]});
                                else if (Byte_i[7:5] == 3'b000) col_d = col_nib_arg;
                            end
`endif
                        end
                    endcase
                end
                ARG_CONTRAST:   contrast_d = Byte_i;
                ARG_COL_START:  col_start_d = col_arg;
                ARG_COL_END: begin
                    col_end_d = col_end_arg;
                    col_d     = col_start_q;
                end
                ARG_PAGE_START: page_start_d = page_arg;
                ARG_PAGE_END: begin
                    page_end_d = page_end_arg;
                    page_d     = page_start_q;
                end
`ifdef SSD1306_ADDR_MODE_EN
                ARG_MODE: if (Byte_i[1:0] != 2'b11) mode_d = Byte_i[1:0];
`endif
                default: ;
            endcase
        end
    end

    assign WriteEnable_o  = we_q;
    assign WriteAddress_o = addr_q;
    assign WriteData_o    = data_q;
    assign DisplayOn_o    = disp_q;
    assign Invert_o       = inv_q;
    assign Contrast_o     = contrast_q;
endmodule

// File: tb/tb_ssd1306_command_decoder.sv
// Directed bench for ssd1306_command_decoder: command decoding, window addressing, CS abort and reset behaviour.
module tb_ssd1306_command_decoder;
    logic        Clock;
    logic        Reset;
    logic [7:0]  Byte_i;
    logic        ByteValid_i;
    logic        DC_i;
    logic        CsStart_i;
    logic        WriteEnable_o;
    logic [10:0] WriteAddress_o;
    logic [7:0]  WriteData_o;
    logic        DisplayOn_o;
    logic        Invert_o;
    logic [7:0]  Contrast_o;

    int checks = 0;
    int errors = 0;

    ssd1306_command_decoder dut (
        .Clock(Clock), .Reset(Reset), .Byte_i(Byte_i), .ByteValid_i(ByteValid_i),
        .DC_i(DC_i), .CsStart_i(CsStart_i), .WriteEnable_o(WriteEnable_o),
        .WriteAddress_o(WriteAddress_o), .WriteData_o(WriteData_o),
        .DisplayOn_o(DisplayOn_o), .Invert_o(Invert_o), .Contrast_o(Contrast_o)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents one byte for a single cycle; registered outputs are settled on return.
    task automatic send(input logic [7:0] b, input logic dc, input logic cs);
        @(negedge Clock);
        Byte_i = b; DC_i = dc; ByteValid_i = 1'b1; CsStart_i = cs;
        @(negedge Clock);
        ByteValid_i = 1'b0; CsStart_i = 1'b0;
    endtask

    task automatic cmd(input logic [7:0] b);
        send(b, 1'b0, 1'b0);
    endtask

    task automatic wr(input string tag, input logic [7:0] b, input int exp_addr);
        send(b, 1'b1, 1'b0);
        chk({tag, "_we"}, 32'(WriteEnable_o), 32'd1);
        chk({tag, "_addr"}, 32'(WriteAddress_o), 32'(exp_addr));
        chk({tag, "_data"}, 32'(WriteData_o), 32'(b));
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
    endtask

    initial begin
        Reset = 1'b1; Byte_i = '0; ByteValid_i = 1'b0; DC_i = 1'b0; CsStart_i = 1'b0;
        do_reset();
        chk("rst_we", 32'(WriteEnable_o), 32'd0);
        chk("rst_addr", 32'(WriteAddress_o), 32'd0);
        chk("rst_data", 32'(WriteData_o), 32'd0);
        chk("rst_disp", 32'(DisplayOn_o), 32'd0);
        chk("rst_inv", 32'(Invert_o), 32'd0);
        chk("rst_contrast", 32'(Contrast_o), 32'h7F);

        // Basic horizontal writes from the reset window.
        wr("t1a", 8'h11, 0);
        wr("t1b", 8'h22, 1);
        wr("t1c", 8'h33, 2);
        cmd(8'hE3);
        chk("t1_we_idle", 32'(WriteEnable_o), 32'd0);
        chk("t1_disp", 32'(DisplayOn_o), 32'd0);
        chk("t1_contrast", 32'(Contrast_o), 32'h7F);

        // Column 10..12, page 2..3 window with wrap back to the window origin.
        cmd(8'h21); cmd(8'd10); cmd(8'd12);
        cmd(8'h22); cmd(8'd2);  cmd(8'd3);
        wr("t2a", 8'hA0, 266);
        wr("t2b", 8'hA1, 267);
        wr("t2c", 8'hA2, 268);
        wr("t2d", 8'hA3, 394);
        wr("t2e", 8'hA4, 395);
        wr("t2f", 8'hA5, 396);
        wr("t2g", 8'hA6, 266);

        // Data byte abandons a pending contrast argument.
        cmd(8'h81);
        wr("t3_abandon", 8'h55, 267);
        chk("t3_contrast_kept", 32'(Contrast_o), 32'h7F);
        cmd(8'hAF);
        chk("t3_disp_on", 32'(DisplayOn_o), 32'd1);
        cmd(8'h81); cmd(8'h30);
        chk("t3_contrast_set", 32'(Contrast_o), 32'h30);

        // Saturated column arguments with end forced up to start.
        cmd(8'h22); cmd(8'd0); cmd(8'd11);
        cmd(8'h21); cmd(8'd200); cmd(8'd5);
        wr("t4a", 8'h01, 127);
        wr("t4b", 8'h02, 255);

        // CS start aborts the pending page command; window and pointers survive.
        cmd(8'h22);
        send(8'h00, 1'b0, 1'b1);
        cmd(8'hA7);
        chk("t5_invert", 32'(Invert_o), 32'd1);
        wr("t5a", 8'h03, 383);
        wr("t5b", 8'h04, 511);
        cmd(8'h22);
        send(8'hA6, 1'b0, 1'b1);
        chk("t5_cs_same_cycle", 32'(Invert_o), 32'd0);
        wr("t5c", 8'h05, 639);

        // Skip-class command discards its argument.
        cmd(8'hAE);
        chk("t5_disp_off", 32'(DisplayOn_o), 32'd0);
        cmd(8'hA8); cmd(8'hAF);
        chk("t5_skip_arg", 32'(DisplayOn_o), 32'd0);
        cmd(8'hAF);
        chk("t5_disp_on2", 32'(DisplayOn_o), 32'd1);

        // Asynchronous reset in the middle of a contrast command.
        cmd(8'h81);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        chk("rstm_disp", 32'(DisplayOn_o), 32'd0);
        chk("rstm_contrast", 32'(Contrast_o), 32'h7F);
        chk("rstm_addr", 32'(WriteAddress_o), 32'd0);
        @(negedge Clock);
        Reset = 1'b1;
        cmd(8'h33);
        chk("rstm_fsm_idle", 32'(Contrast_o), 32'h7F);
        wr("rstm_ptr", 8'h99, 0);

        // Addressing mode 0x20,0x01 followed by full window setup.
        do_reset();
        cmd(8'h20); cmd(8'h01);
        cmd(8'h21); cmd(8'd0); cmd(8'd127);
        cmd(8'h22); cmd(8'd0); cmd(8'd11);
        for (int i = 0; i < 13; i++) begin
            int exp_a;
`ifdef SSD1306_ADDR_MODE_EN
            exp_a = (i < 12) ? i * 128 : 1;
`else
            exp_a = i;
`endif
            wr($sformatf("t6_%0d", i), 8'(i + 8'h40), exp_a);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
